// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants and helpers for the 7-segment scan driver:
//            hex font table, output polarity helpers, digit count bound.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Largest digit count the scan driver is meant to be built with.
  localparam int MAX_DIGITS = 8;

  // Font, entry n at bits [7n+6:7n]; pattern bit0 = segment a ... bit6 = g.
  localparam logic [16*7-1:0] C_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] font_of(input logic [3:0] nib);
    return C_FONT[nib*7 +: 7];
  endfunction

  // Convert a "1 = lit" pattern to pin level.
  function automatic logic [6:0] seg_pol(input logic [6:0] pat, input bit active_low);
    return active_low ? ~pat : pat;
  endfunction

  function automatic logic pol_bit(input logic on, input bit active_low);
    return active_low ? ~on : on;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg7
// Purpose  : Combinational hex nibble to 7-segment pattern (1 = lit).
// Ports    : nibble  in  4   hex digit
//            pattern out 7   {g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = font_of(nibble);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Multiplexed 7-segment display scanner with shadow-buffered
//            loads, PWM brightness, leading-zero blanking, per-digit decimal
//            point and blink, and a one-cycle dead time per digit slot.
// Ports    : clk         in  1            system clock
//            rst         in  1            asynchronous active-high reset
//            value       in  4*DIGITS     hex nibbles, digit 0 least significant
//            dp          in  DIGITS       decimal point per digit
//            blink_en    in  DIGITS       per-digit blink enable
//            load        in  1            request shadow capture at frame wrap
//            brightness  in  BRIGHT_BITS  duty level, 0 = dark
//            blank_lz    in  1            suppress leading zeros
//            seg         out 7            {g,f,e,d,c,b,a}
//            seg_dp      out 1            decimal point segment
//            ca          out DIGITS       digit enables
//            frame_wrap  out 1            pulse on first cycle of digit 0
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 3,
  parameter int DIV_BITS       = 14,
  parameter int BRIGHT_BITS    = 4,
  parameter int BLINK_BITS     = 5,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*DIGITS-1:0]     value,
  input  logic [DIGITS-1:0]       dp,
  input  logic [DIGITS-1:0]       blink_en,
  input  logic                    load,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [DIGITS-1:0]       ca,
  output logic                    frame_wrap
);

  localparam int                IDXW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0]   C_LAST    = IDXW'(DIGITS - 1);
  localparam logic [6:0]        C_SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              C_DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] C_CA_OFF  = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Scan state
  logic [DIV_BITS-1:0]    r_presc;
  logic [IDXW-1:0]        r_idx;
  logic [BLINK_BITS-1:0]  r_blink;
  logic                   r_frame_wrap;

  // Shadow copy shown on the display; only changes at a frame boundary.
  logic                   r_pending;
  logic [4*DIGITS-1:0]    r_sh_value;
  logic [DIGITS-1:0]      r_sh_dp;
  logic [DIGITS-1:0]      r_sh_blink;

  // Registered pin drivers
  logic [6:0]             r_seg;
  logic                   r_seg_dp;
  logic [DIGITS-1:0]      r_ca;

  logic                   w_term;
  logic                   w_wrap;
  logic [BRIGHT_BITS-1:0] w_phase;
  logic [3:0]             w_nib;
  logic [6:0]             w_font;
  logic [DIGITS-1:0]      w_lz_blank;
  logic                   w_lz_seen_nz;
  logic                   w_on;
  logic                   w_seg_on;
  logic                   w_dp_on;
  logic [DIGITS-1:0]      w_ca_raw;

  assign w_term = &r_presc;
  assign w_wrap = w_term && (r_idx == C_LAST);

  // Prescaler, digit index, blink frame counter, frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_blink      <= '0;
      r_frame_wrap <= 1'b0;
    end else begin
      r_presc      <= r_presc + 1'b1;
      r_frame_wrap <= w_wrap;
      if (w_term) begin
        r_idx <= (r_idx == C_LAST) ? '0 : r_idx + 1'b1;
      end
      if (w_wrap) begin
        r_blink <= r_blink + 1'b1;
      end
    end
  end

  // Shadow capture happens only on the last cycle of a frame, so a frame
  // never mixes old and new digits. A load in that same cycle is honoured
  // directly; otherwise the request waits in r_pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_sh_value <= '0;
      r_sh_dp    <= '0;
      r_sh_blink <= '0;
    end else if (w_wrap) begin
      if (r_pending || load) begin
        r_sh_value <= value;
        r_sh_dp    <= dp;
        r_sh_blink <= blink_en;
      end
      r_pending <= 1'b0;
    end else if (load) begin
      r_pending <= 1'b1;
    end
  end

  // Leading-zero mask: walk from the top digit down; a digit stays blanked
  // until a nonzero nibble has been seen at or above it. Digit 0 is excluded.
  always_comb begin
    w_lz_blank   = '0;
    w_lz_seen_nz = 1'b0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (r_sh_value[4*d +: 4] != 4'h0) begin
        w_lz_seen_nz = 1'b1;
      end
      w_lz_blank[d] = blank_lz && !w_lz_seen_nz;
    end
  end

  assign w_nib   = r_sh_value[4*r_idx +: 4];
  assign w_phase = r_presc[DIV_BITS-1 -: BRIGHT_BITS];

  hex_to_seg7 u_font (
    .nibble  (w_nib),
    .pattern (w_font)
  );

  // Slot is active outside the dead cycle, inside the PWM window and not in
  // the blink-off half period. LZ blanking kills segments but keeps the dp.
  assign w_on     = (r_presc != '0) && (w_phase < brightness)
                    && !(r_sh_blink[r_idx] && r_blink[BLINK_BITS-1]);
  assign w_seg_on = w_on && !w_lz_blank[r_idx];
  assign w_dp_on  = w_on && r_sh_dp[r_idx];
  assign w_ca_raw = (w_seg_on || w_dp_on) ? (DIGITS'(1) << r_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg    <= C_SEG_OFF;
      r_seg_dp <= C_DP_OFF;
      r_ca     <= C_CA_OFF;
    end else begin
      r_seg    <= seg_pol(w_seg_on ? w_font : 7'h00, SEG_ACTIVE_LOW);
      r_seg_dp <= pol_bit(w_dp_on, SEG_ACTIVE_LOW);
      r_ca     <= DIG_ACTIVE_LOW ? ~w_ca_raw : w_ca_raw;
    end
  end

  assign seg        = r_seg;
  assign seg_dp     = r_seg_dp;
  assign ca         = r_ca;
  assign frame_wrap = r_frame_wrap;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Directed self-checking bench for seg7_scan_driver with
//            DIGITS=3, DIV_BITS=4, BRIGHT_BITS=2, BLINK_BITS=2, active-low.
//            Slot = 16 clk, frame = 48 clk. Positions are counted in
//            negedges from the last observed frame_wrap; the output seen at
//            position 16*d+p+1 is the one computed from digit d, prescaler p.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] value = 12'h000;
  logic [2:0]  dp = 3'b000;
  logic [2:0]  blink_en = 3'b000;
  logic        load = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [2:0]  ca;
  logic        frame_wrap;

  int n_vec = 0;
  int n_bad = 0;
  int pos   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS         (3),
    .DIV_BITS       (4),
    .BRIGHT_BITS    (2),
    .BLINK_BITS     (2),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp         (dp),
    .blink_en   (blink_en),
    .load       (load),
    .brightness (brightness),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .seg_dp     (seg_dp),
    .ca         (ca),
    .frame_wrap (frame_wrap)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic show(input string tag, input logic [6:0] s, input logic d, input logic [2:0] c);
    check_eq({tag, "_seg"}, 32'(seg), 32'(s));
    check_eq({tag, "_dp"},  32'(seg_dp), 32'(d));
    check_eq({tag, "_ca"},  32'(ca), 32'(c));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    pos += n;
  endtask

  task automatic at_slot(input int d, input int p);
    int tgt;
    tgt = 16 * d + p + 1;
    if (tgt > pos) step(tgt - pos);
  endtask

  task automatic sync_wrap();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_wrap) seen = 1'b1;
    end
    check_eq("wrap_seen", 32'(seen), 32'd1);
    pos = 0;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic release_check(input string tag);
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
    step(1);
    show({tag, "_p0"}, 7'h7F, 1'b1, 3'b111);
    step(1);
    show({tag, "_p1"}, 7'h40, 1'b1, 3'b110);
  endtask

  initial begin
    int cnt;
    #12;
    show("rst_hold", 7'h7F, 1'b1, 3'b111);
    check_eq("rst_fw", 32'(frame_wrap), 32'd0);
    release_check("rel");

    // Asynchronous reset in the middle of a lit slot
    step(3);
    check_eq("pre_arst_ca", 32'(ca), 32'(3'b110));
    #2 rst = 1'b1;
    #1 show("arst", 7'h7F, 1'b1, 3'b111);
    check_eq("arst_fw", 32'(frame_wrap), 32'd0);
    release_check("rel2");

    // Basic scan of 0x123
    value = 12'h123;
    pulse_load();
    sync_wrap();
    at_slot(0, 0);  show("dead",   7'h7F, 1'b1, 3'b111);
    at_slot(0, 1);  show("d0_3",   7'h30, 1'b1, 3'b110);
    at_slot(0, 15); show("phase3", 7'h7F, 1'b1, 3'b111);
    at_slot(1, 5);  show("d1_2",   7'h24, 1'b1, 3'b101);
    at_slot(2, 1);  show("d2_1",   7'h79, 1'b1, 3'b011);

    // Frame period
    sync_wrap();
    step(1);
    check_eq("fw_pulse_low", 32'(frame_wrap), 32'd0);
    cnt = 1;
    while (!frame_wrap && cnt < 200) begin
      step(1);
      cnt++;
    end
    check_eq("fw_period", 32'(cnt), 32'd48);
    pos = 0;

    // Tear-free: mid-frame load only shows up next frame
    value = 12'h456;
    at_slot(1, 0);
    pulse_load();
    at_slot(2, 1);  show("tf_old", 7'h79, 1'b1, 3'b011);
    sync_wrap();
    at_slot(0, 1);  show("tf_d0",  7'h02, 1'b1, 3'b110);
    at_slot(1, 1);  show("tf_d1",  7'h12, 1'b1, 3'b101);
    at_slot(2, 1);  show("tf_d2",  7'h19, 1'b1, 3'b011);

    // Load asserted exactly in the wrap cycle is taken at that wrap
    step(47 - pos);
    value = 12'h789;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
    check_eq("co_fw", 32'(frame_wrap), 32'd1);
    pos = 0;
    at_slot(0, 1);  show("co_d0", 7'h10, 1'b1, 3'b110);
    at_slot(2, 1);  show("co_d2", 7'h78, 1'b1, 3'b011);

    // Brightness
    sync_wrap();
    brightness = 2'd1;
    at_slot(0, 1);  show("br1_p1", 7'h10, 1'b1, 3'b110);
    at_slot(0, 3);  show("br1_p3", 7'h10, 1'b1, 3'b110);
    at_slot(0, 4);  show("br1_p4", 7'h7F, 1'b1, 3'b111);
    brightness = 2'd0;
    at_slot(1, 1);  show("br0_d1", 7'h7F, 1'b1, 3'b111);
    at_slot(2, 8);  show("br0_d2", 7'h7F, 1'b1, 3'b111);
    brightness = 2'd3;

    // Leading-zero blanking
    value    = 12'h007;
    blank_lz = 1'b1;
    pulse_load();
    sync_wrap();
    at_slot(0, 1);  show("lz7_d0", 7'h78, 1'b1, 3'b110);
    at_slot(1, 1);  show("lz7_d1", 7'h7F, 1'b1, 3'b111);
    at_slot(2, 1);  show("lz7_d2", 7'h7F, 1'b1, 3'b111);
    value = 12'h000;
    dp    = 3'b100;
    pulse_load();
    sync_wrap();
    at_slot(0, 1);  show("lz0_d0", 7'h40, 1'b1, 3'b110);
    at_slot(1, 1);  show("lz0_d1", 7'h7F, 1'b1, 3'b111);
    at_slot(2, 1);  show("lz0_d2", 7'h7F, 1'b0, 3'b011);

    // Blink: restart from reset so the frame counter is known
    blank_lz = 1'b0;
    dp       = 3'b000;
    value    = 12'h123;
    blink_en = 3'b010;
    @(negedge clk);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    pos = 0;
    pulse_load();
    // Shadow is captured at the first wrap, when the counter moves to 1.
    for (int f = 1; f <= 5; f++) begin
      sync_wrap();
      at_slot(0, 1);  show($sformatf("bl%0d_d0", f), 7'h30, 1'b1, 3'b110);
      at_slot(1, 1);
      if ((f % 4) < 2) show($sformatf("bl%0d_d1", f), 7'h24, 1'b1, 3'b101);
      else             show($sformatf("bl%0d_d1", f), 7'h7F, 1'b1, 3'b111);
      at_slot(2, 1);  show($sformatf("bl%0d_d2", f), 7'h79, 1'b1, 3'b011);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
